// File: rtl/joystick_gesture_filter.sv
// Joystick conditioner: dead zone with hysteresis, dominant-axis resolution, stability debounce, press strobes.
// Optional JOYSTICK_REPEAT_EN adds periodic auto-repeat strobes while a direction is held.
module joystick_gesture_filter #(
  parameter int unsigned CENTER         = 128,
  parameter int unsigned DEAD           = 40,
  parameter int unsigned HYST           = 10,
  parameter int unsigned SAMPLE_DIV     = 100000,
  parameter int unsigned STABLE_SAMPLES = 20,
  parameter int unsigned REPEAT_SAMPLES = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] x_pos_i,
  input  logic [7:0] y_pos_i,
  output logic [3:0] direction_o,
  output logic       dir_strobe_o
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_SAMPLES);
  localparam logic [8:0]       CENTER_9 = 9'(CENTER);
  localparam logic [7:0]       DEAD_TH  = 8'(DEAD);
  localparam logic [7:0]       REL_TH   = 8'(DEAD - HYST);

  localparam logic [3:0] DIR_NONE  = 4'd0;
  localparam logic [3:0] DIR_UP    = 4'd1;
  localparam logic [3:0] DIR_DOWN  = 4'd2;
  localparam logic [3:0] DIR_LEFT  = 4'd3;
  localparam logic [3:0] DIR_RIGHT = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HELD,
    REL
  } state_e;

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic             smp_vld_q;

  logic [8:0]       dx;
  logic [8:0]       dy;
  logic [7:0]       adx;
  logic [7:0]       ady;
  logic [3:0]       cand;
  logic [7:0]       held_mag;
  logic             held_ok;

  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       dir_q, dir_d;
  logic             stb_q, stb_d;

`ifdef JOYSTICK_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SAMPLES);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = (rep_q == REP_MAX) ? rep_q : rep_q + REP_ONE;
`endif

  // Sample divider: positions are captured only on the terminal count, and the
  // qualifier acts one cycle later on the captured values.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      div_q     <= tick ? '0 : div_q + DIV_ONE;
      smp_vld_q <= tick;
      if (tick) begin
        x_q <= x_pos_i;
        y_q <= y_pos_i;
      end
    end
  end

  // |v| of a 9-bit two's-complement value, saturated to 8 bits.
  function automatic logic [7:0] mag8(input logic [8:0] v);
    logic [8:0] a;
    a = v[8] ? (~v + 9'd1) : v;
    return a[8] ? 8'hFF : a[7:0];
  endfunction

  assign dx  = {1'b0, x_q} - CENTER_9;
  assign dy  = {1'b0, y_q} - CENTER_9;
  assign adx = mag8(dx);
  assign ady = mag8(dy);

  // Dominant axis wins; a tie goes to Y.
  always_comb begin
    cand = DIR_NONE;
    if (ady >= adx) begin
      if (ady >= DEAD_TH) begin
        cand = dy[8] ? DIR_DOWN : DIR_UP;
      end
    end else if (adx >= DEAD_TH) begin
      cand = dx[8] ? DIR_LEFT : DIR_RIGHT;
    end
  end

  // While held, only the deflection along the held axis and sign keeps it alive.
  always_comb begin
    held_mag = 8'd0;
    case (cand_q)
      DIR_UP:    held_mag = dy[8] ? 8'd0 : ady;
      DIR_DOWN:  held_mag = dy[8] ? ady : 8'd0;
      DIR_LEFT:  held_mag = dx[8] ? adx : 8'd0;
      DIR_RIGHT: held_mag = dx[8] ? 8'd0 : adx;
      default:   held_mag = 8'd0;
    endcase
  end

  assign held_ok = (held_mag >= REL_TH);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cand_q  <= DIR_NONE;
      cnt_q   <= '0;
      dir_q   <= DIR_NONE;
      stb_q   <= 1'b0;
`ifdef JOYSTICK_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      stb_q   <= stb_d;
`ifdef JOYSTICK_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    stb_d   = 1'b0;
`ifdef JOYSTICK_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (smp_vld_q) begin
      case (state_q)
        IDLE: begin
          if (cand != DIR_NONE) begin
            state_d = QUAL;
            cand_d  = cand;
            cnt_d   = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              state_d = HELD;
              cnt_d   = '0;
              dir_d   = cand;
              stb_d   = 1'b1;
`ifdef JOYSTICK_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end
        end

        QUAL: begin
          if (cand == DIR_NONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            // A different direction restarts qualification rather than aborting it.
            cand_d = cand;
            cnt_d  = (cand == cand_q) ? cnt_inc : CNT_ONE;
            if (cnt_d == CNT_MAX) begin
              state_d = HELD;
              cnt_d   = '0;
              dir_d   = cand;
              stb_d   = 1'b1;
`ifdef JOYSTICK_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end
        end

        HELD: begin
          if (!held_ok) begin
            state_d = REL;
            cnt_d   = CNT_ONE;
`ifdef JOYSTICK_REPEAT_EN
            rep_d   = '0;
`endif
            if (CNT_ONE == CNT_MAX) begin
              state_d = IDLE;
              cnt_d   = '0;
              dir_d   = DIR_NONE;
            end
          end else begin
`ifdef JOYSTICK_REPEAT_EN
            if (rep_inc == REP_MAX) begin
              stb_d = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end

        REL: begin
          if (held_ok) begin
            state_d = HELD;
            cnt_d   = '0;
`ifdef JOYSTICK_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = IDLE;
              cnt_d   = '0;
              dir_d   = DIR_NONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          dir_d   = DIR_NONE;
        end
      endcase
    end
  end

  assign direction_o  = dir_q;
  assign dir_strobe_o = stb_q;

endmodule

// File: tb/tb_joystick_gesture_filter.sv
// Directed bench for joystick_gesture_filter with SAMPLE_DIV=4, STABLE_SAMPLES=3, DEAD=40, HYST=10, REPEAT_SAMPLES=8.
module tb_joystick_gesture_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x_pos = 8'd128;
  logic [7:0] y_pos = 8'd128;
  logic [3:0] direction;
  logic       dir_strobe;

  int total = 0;
  int bad   = 0;

  joystick_gesture_filter #(
    .CENTER        (128),
    .DEAD          (40),
    .HYST          (10),
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3),
    .REPEAT_SAMPLES(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .x_pos_i     (x_pos),
    .y_pos_i     (y_pos),
    .direction_o (direction),
    .dir_strobe_o(dir_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered 1 time unit after a processing edge; drives one sample interval
  // and returns 1 time unit after the edge where that sample is acted upon.
  task automatic tick(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] exp_dir, input logic exp_stb);
    x_pos = x;
    y_pos = y;
    @(posedge clk); #1;
    check({tag, " strobe_width"}, {3'b000, dir_strobe}, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("tick %s x=%0d y=%0d dir=%0d stb=%0b", tag, x, y, direction, dir_strobe);
    check({tag, " dir"}, direction, exp_dir);
    check({tag, " stb"}, {3'b000, dir_strobe}, {3'b000, exp_stb});
  endtask

  // Large deflection present only between ticks; the tick itself sees centre.
  task automatic tick_glitch(input string tag);
    x_pos = 8'd0;
    y_pos = 8'd255;
    @(posedge clk); #1;
    check({tag, " strobe_width"}, {3'b000, dir_strobe}, 4'd0);
    @(posedge clk); #1;
    x_pos = 8'd128;
    y_pos = 8'd128;
    repeat (2) @(posedge clk);
    #1;
    $display("tick %s glitch dir=%0d stb=%0b", tag, direction, dir_strobe);
    check({tag, " dir"}, direction, 4'd0);
    check({tag, " stb"}, {3'b000, dir_strobe}, 4'd0);
  endtask

  initial begin
    logic exp_stb;
    logic [3:0] exp_dir;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset dir", direction, 4'd0);
    check("reset stb", {3'b000, dir_strobe}, 4'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Press up, then release through the stability window
    tick("up1", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("up2", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("up3", 8'd128, 8'd200, 4'd1, 1'b1);
    tick("uprel1", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("uprel2", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("uprel3", 8'd128, 8'd128, 4'd0, 1'b0);

    // Inside dead zone: dx=32 never presses
    for (int i = 0; i < 4; i++) tick($sformatf("dead%0d", i), 8'd160, 8'd128, 4'd0, 1'b0);

    // Between-tick excursions are invisible
    for (int i = 0; i < 3; i++) tick_glitch($sformatf("glitch%0d", i));

    // Tie |dx|=|dy|=72 resolves to Y (down)
    tick("tie1", 8'd200, 8'd56, 4'd0, 1'b0);
    tick("tie2", 8'd200, 8'd56, 4'd0, 1'b0);
    tick("tie3", 8'd200, 8'd56, 4'd2, 1'b1);
    tick("tie4", 8'd200, 8'd56, 4'd2, 1'b0);
    tick("tierel1", 8'd128, 8'd128, 4'd2, 1'b0);
    tick("tierel2", 8'd128, 8'd128, 4'd2, 1'b0);
    tick("tierel3", 8'd128, 8'd128, 4'd0, 1'b0);

    // Hysteresis on a right press
    tick("rt1", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rt2", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rt3", 8'd200, 8'd128, 4'd4, 1'b1);
    tick("hyst160a", 8'd160, 8'd128, 4'd4, 1'b0);
    tick("hyst160b", 8'd160, 8'd128, 4'd4, 1'b0);
    tick("hyst150a", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("hyst150b", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("hyst150c", 8'd150, 8'd128, 4'd0, 1'b0);
    tick("rt2_1", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rt2_2", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rt2_3", 8'd200, 8'd128, 4'd4, 1'b1);
    tick("partrel1", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("partrel2", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("rehold1", 8'd200, 8'd128, 4'd4, 1'b0);
    tick("rehold2", 8'd200, 8'd128, 4'd4, 1'b0);
    tick("rtrel1", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("rtrel2", 8'd150, 8'd128, 4'd4, 1'b0);
    tick("rtrel3", 8'd150, 8'd128, 4'd0, 1'b0);

    // Glitch reject: broken run restarts qualification
    tick("gl1", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("gl2", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("gl3", 8'd128, 8'd128, 4'd0, 1'b0);
    tick("gl4", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("gl5", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("gl6", 8'd128, 8'd200, 4'd1, 1'b1);
    tick("glrel1", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("glrel2", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("glrel3", 8'd128, 8'd128, 4'd0, 1'b0);

    // Left held; other-axis dominance ignored; swap to up needs a full release
    tick("lf1", 8'd56, 8'd128, 4'd0, 1'b0);
    tick("lf2", 8'd56, 8'd128, 4'd0, 1'b0);
    tick("lf3", 8'd56, 8'd128, 4'd3, 1'b1);
    tick("lfoff1", 8'd56, 8'd255, 4'd3, 1'b0);
    tick("lfoff2", 8'd56, 8'd255, 4'd3, 1'b0);
    tick("swap1", 8'd128, 8'd200, 4'd3, 1'b0);
    tick("swap2", 8'd128, 8'd200, 4'd3, 1'b0);
    tick("swap3", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("swap4", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("swap5", 8'd128, 8'd200, 4'd0, 1'b0);
    tick("swap6", 8'd128, 8'd200, 4'd1, 1'b1);
    tick("swrel1", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("swrel2", 8'd128, 8'd128, 4'd1, 1'b0);
    tick("swrel3", 8'd128, 8'd128, 4'd0, 1'b0);

    // Reset while the press strobe is still high
    tick("rs1", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rs2", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("rs3", 8'd200, 8'd128, 4'd4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-press dir=%0d stb=%0b", direction, dir_strobe);
    check("midreset dir", direction, 4'd0);
    check("midreset stb", {3'b000, dir_strobe}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick("post1", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("post2", 8'd200, 8'd128, 4'd0, 1'b0);
    tick("post3", 8'd200, 8'd128, 4'd4, 1'b1);
    tick("postrel1", 8'd128, 8'd128, 4'd4, 1'b0);
    tick("postrel2", 8'd128, 8'd128, 4'd4, 1'b0);
    tick("postrel3", 8'd128, 8'd128, 4'd0, 1'b0);

    // Long hold down: auto-repeat every 8 samples only when enabled
    for (int t = 1; t <= 30; t++) begin
      exp_dir = (t >= 3) ? 4'd2 : 4'd0;
      exp_stb = (t == 3);
`ifdef JOYSTICK_REPEAT_EN
      if (t > 3 && ((t - 3) % 8) == 0) exp_stb = 1'b1;
`endif
      tick($sformatf("hold%0d", t), 8'd128, 8'd56, exp_dir, exp_stb);
    end
    tick("holdrel1", 8'd128, 8'd128, 4'd2, 1'b0);
    tick("holdrel2", 8'd128, 8'd128, 4'd2, 1'b0);
    tick("holdrel3", 8'd128, 8'd128, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
